// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - shared defaults, sizing helpers and element type for kernel_product_pipe
package kernel_pkg;
   localparam int K_DEFAULT    = 7;
   localparam int DW_DEFAULT   = 16;
   localparam int FRAC_DEFAULT = 8;

   typedef logic [DW_DEFAULT-1:0] elem_t;

   function automatic int n_elem(input int k);
      return k * k;
   endfunction

   // Sum of n unsigned dw-bit values can never exceed this width.
   function automatic int sum_w(input int dw, input int n);
      return dw + $clog2(n);
   endfunction
endpackage

// File: rtl/kernel_product_elem.sv
// rtl/kernel_product_elem.sv - one element: operand, product and round/saturate stages
module kernel_product_elem #(
   parameter int DW   = 16,
   parameter int FRAC = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] prod_o,
   output logic          sat_o
);
   logic [DW-1:0]   a_q, b_q;
   logic [2*DW-1:0] p_q;
   logic [2*DW:0]   rnd;
   logic [2*DW:0]   r_full;
   logic [DW-1:0]   prod_d, prod_q;

   // One spare bit keeps the half-LSB addition from wrapping.
   if (FRAC == 0) begin : g_no_round
      assign rnd = {1'b0, p_q};
   end else begin : g_round
      assign rnd = {1'b0, p_q} + ((2*DW+1)'(1) << (FRAC - 1));
   end

   assign r_full = rnd >> FRAC;
   assign sat_o  = |r_full[2*DW:DW];
   assign prod_d = sat_o ? {DW{1'b1}} : r_full[DW-1:0];
   assign prod_o = prod_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         prod_q <= '0;
      end else if (adv_i) begin
         a_q    <= a_i;
         b_q    <= b_i;
         p_q    <= {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
         prod_q <= prod_d;
      end
   end
endmodule

// File: rtl/kernel_product_pipe.sv
// rtl/kernel_product_pipe.sv - element-wise K x K fixed-point kernel product with valid/ready stall
// Optional stage S4 with the product sum is enabled by KERNEL_PRODUCT_SUM_EN.
module kernel_product_pipe
   import kernel_pkg::*;
#(
   parameter int  K    = K_DEFAULT,
   parameter int  DW   = DW_DEFAULT,
   parameter int  FRAC = FRAC_DEFAULT,
   parameter int  CNTW = 32,
   localparam int N    = n_elem(K)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N*DW-1:0]          in_a,
   input  logic [N*DW-1:0]          in_b,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [N*DW-1:0]          out_prod,
`ifdef KERNEL_PRODUCT_SUM_EN
   output logic [sum_w(DW,N)-1:0]   out_sum,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sat_flag,
   output logic [CNTW-1:0]          xfer_cnt
);
   logic            adv;
   logic            v1_q, v2_q, v3_q;
   logic            sat_q, sat_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    sat_vec;
   logic [N*DW-1:0] s3_prod;

   // Single stall for the whole pipe; bubbles travel with the data.
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   for (genvar g = 0; g < N; g++) begin : g_elem
      kernel_product_elem #(
         .DW   (DW),
         .FRAC (FRAC)
      ) u_elem (
         .clk    (clk),
         .rst    (rst),
         .adv_i  (adv),
         .a_i    (in_a[g*DW +: DW]),
         .b_i    (in_b[g*DW +: DW]),
         .prod_o (s3_prod[g*DW +: DW]),
         .sat_o  (sat_vec[g])
      );
   end

   assign sat_d = sat_q | (adv & v2_q & (|sat_vec));
   assign cnt_d = (out_valid & out_ready) ? cnt_q + CNTW'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         sat_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
         end
         sat_q <= sat_d;
         cnt_q <= cnt_d;
      end
   end

   assign sat_flag = sat_q;
   assign xfer_cnt = cnt_q;

`ifdef KERNEL_PRODUCT_SUM_EN
   localparam int SW = sum_w(DW, N);

   logic            v4_q;
   logic [N*DW-1:0] prod4_q;
   logic [SW-1:0]   sum_d, sum_q;

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < N; i++) begin
         sum_d = sum_d + SW'(s3_prod[i*DW +: DW]);
      end
   end

   // Products are delayed one stage so they leave together with their sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         v4_q    <= 1'b0;
         prod4_q <= '0;
         sum_q   <= '0;
      end else if (adv) begin
         v4_q    <= v3_q;
         prod4_q <= s3_prod;
         sum_q   <= sum_d;
      end
   end

   assign out_valid = v4_q;
   assign out_prod  = prod4_q;
   assign out_sum   = sum_q;
`else
   assign out_valid = v3_q;
   assign out_prod  = s3_prod;
`endif
endmodule

// File: tb/tb_kernel_product_pipe.sv
// tb/tb_kernel_product_pipe.sv - directed table-driven bench for kernel_product_pipe
module tb_kernel_product_pipe;
   import kernel_pkg::*;

   localparam int K  = K_DEFAULT;
   localparam int DW = DW_DEFAULT;
   localparam int N  = n_elem(K);
`ifdef KERNEL_PRODUCT_SUM_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N*DW-1:0] in_a, in_b;
   logic            in_valid, out_ready;
   logic            in_ready, in_ready4;
   logic [N*DW-1:0] out_prod, out_prod4;
   logic            out_valid, out_valid4;
   logic            sat_flag, sat_flag4;
   logic [31:0]     xfer_cnt;
   logic [3:0]      xfer_cnt4;
`ifdef KERNEL_PRODUCT_SUM_EN
   logic [sum_w(DW,N)-1:0] out_sum, out_sum4;
`endif
   logic [31:0]     sum_seen;

   kernel_product_pipe #(.K(K), .DW(DW), .FRAC(8), .CNTW(32)) u_dut (
      .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
      .in_ready(in_ready), .out_prod(out_prod),
`ifdef KERNEL_PRODUCT_SUM_EN
      .out_sum(out_sum),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag),
      .xfer_cnt(xfer_cnt)
   );

   kernel_product_pipe #(.K(K), .DW(DW), .FRAC(8), .CNTW(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
      .in_ready(in_ready4), .out_prod(out_prod4),
`ifdef KERNEL_PRODUCT_SUM_EN
      .out_sum(out_sum4),
`endif
      .out_valid(out_valid4), .out_ready(out_ready), .sat_flag(sat_flag4),
      .xfer_cnt(xfer_cnt4)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      elem_t a;
      elem_t b;
      elem_t p;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
      int bad = -1;
      n_chk++;
      for (int e = N - 1; e >= 0; e--)
         if (act[e*DW +: DW] !== exp[e*DW +: DW]) bad = e;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: elem %0d got 0x%0h expected 0x%0h", name, bad,
                  act[bad*DW +: DW], exp[bad*DW +: DW]);
      end
   endtask

   function automatic logic [N*DW-1:0] fill(input elem_t v);
      logic [N*DW-1:0] r;
      for (int e = 0; e < N; e++) r[e*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [N*DW-1:0] mk_a(input int j);
      logic [N*DW-1:0] r;
      for (int e = 0; e < N; e++) r[e*DW +: DW] = 16'h0100 + 16'(j * 64 + e);
      return r;
   endfunction

   // Sends one kernel with out_ready high and returns what came out, then lets it transfer.
   task automatic run_one(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                          output int lat, output logic [N*DW-1:0] prod,
                          output logic sat_pre, output logic sat_at);
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      sat_pre = sat_flag;
      while (!out_valid && lat < 20) begin
         sat_pre = sat_flag;
         @(posedge clk); #1;
         lat++;
      end
      prod   = out_prod;
      sat_at = sat_flag;
`ifdef KERNEL_PRODUCT_SUM_EN
      sum_seen = 32'(out_sum);
`else
      sum_seen = 32'd0;
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      int              lat;
      logic [N*DW-1:0] prod, a_v, b_v, e_v;
      logic            sp, sa;
      int              sent, got, seen, bad;
      logic            hold;
      logic [N*DW-1:0] prev;

      tbl[0] = '{16'h0180, 16'h0200, 16'h0300};
      tbl[1] = '{16'h0001, 16'h0080, 16'h0001};
      tbl[2] = '{16'h0001, 16'h007F, 16'h0000};
      tbl[3] = '{16'h0100, 16'h0100, 16'h0100};
      tbl[4] = '{16'hFFFF, 16'h0100, 16'hFFFF};
      tbl[5] = '{16'h0000, 16'hFFFF, 16'h0000};
      tbl[6] = '{16'h1234, 16'h0010, 16'h0123};
      tbl[7] = '{16'h00FF, 16'h00FF, 16'h00FE};
      tbl[8] = '{16'h0003, 16'h0080, 16'h0002};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sat_flag", sat_flag, 0);
      check("rst_xfer_cnt", xfer_cnt, 0);
      check_vec("rst_out_prod", out_prod, '0);
      check("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 9; i++) begin
         run_one(fill(tbl[i].a), fill(tbl[i].b), lat, prod, sp, sa);
         check($sformatf("tbl%0d_latency", i), lat, LAT);
         check_vec($sformatf("tbl%0d_prod", i), prod, fill(tbl[i].p));
         check($sformatf("tbl%0d_sat", i), sa, 0);
         check($sformatf("tbl%0d_xfer", i), xfer_cnt, i + 1);
`ifdef KERNEL_PRODUCT_SUM_EN
         check($sformatf("tbl%0d_sum", i), sum_seen, 49 * tbl[i].p);
`endif
      end

      a_v = fill(16'h0100); b_v = fill(16'h0100); e_v = fill(16'h0100);
      a_v[24*DW +: DW] = 16'hFF00;
      b_v[24*DW +: DW] = 16'h0200;
      e_v[24*DW +: DW] = 16'hFFFF;
      run_one(a_v, b_v, lat, prod, sp, sa);
      check("sat_latency", lat, LAT);
      check_vec("sat_prod", prod, e_v);
      check("sat_before_valid", sp, 0);
      check("sat_with_valid", sa, 1);
      for (int i = 0; i < 10; i++) begin
         run_one(fill(16'h0100), fill(16'h0100), lat, prod, sp, sa);
         check_vec("clean_prod", prod, fill(16'h0100));
      end
      check("sat_sticky", sat_flag, 1);
      check("xfer_after_sat", xfer_cnt, 20);

      @(negedge clk);
      in_a = fill(16'h0300); in_b = fill(16'h0100); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_a = fill(16'h0400);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_xfer", xfer_cnt, 0);
      check("midrst_sat", sat_flag, 0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_dropped", seen, 0);
      run_one(fill(16'h0200), fill(16'h0080), lat, prod, sp, sa);
      check("midrst_new_latency", lat, LAT);
      check_vec("midrst_new_prod", prod, fill(16'h0100));
      check("midrst_new_xfer", xfer_cnt, 1);

      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      sent = 0; got = 0; hold = 1'b0; prev = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         in_valid  = (sent < 8);
         in_a      = mk_a(sent);
         in_b      = fill(16'h0100);
         out_ready = !(cyc >= 5 && cyc <= 9);
         #1;
         if (cyc >= 5 && cyc <= 9) check($sformatf("bp_in_ready_c%0d", cyc), in_ready, 0);
         if (hold) begin
            check("bp_hold_valid", out_valid, 1);
            check_vec("bp_hold_data", out_prod, prev);
         end
         if (out_valid && out_ready) begin
            if (got < 8) check_vec($sformatf("bp_order%0d", got), out_prod, mk_a(got));
            got++;
         end
         hold = out_valid && !out_ready;
         prev = out_prod;
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      check("bp_sent", sent, 8);
      check("bp_received", got, 8);
      @(posedge clk); #1;
      check("bp_xfer", xfer_cnt, 8);

      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      sent = 0; bad = 0;
      for (int cyc = 0; cyc < 45; cyc++) begin
         @(negedge clk);
         in_valid  = (cyc % 2 == 0) && (sent < 17);
         in_a      = fill(16'h0100);
         in_b      = fill(16'h0100);
         out_ready = 1'b1;
         #1;
         if (out_valid !== ((cyc >= LAT) && ((cyc - LAT) % 2 == 0) && ((cyc - LAT) / 2 < 17))) begin
            if (bad == 0) $display("FAIL wrap_bubble_pattern: cycle %0d got out_valid %0b", cyc, out_valid);
            bad++;
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      check("wrap_bubble_errors", bad, 0);
      check("wrap_xfer32", xfer_cnt, 17);
      check("wrap_xfer4", xfer_cnt4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
